// File: rtl/fetch_unit.sv
// Instruction-fetch stage: writable instruction memory, a program counter and a
// prefetch FIFO presenting {pc, inst} to decode. A redirect flushes all queued work.
module fetch_unit #(
    parameter int ADDR_W     = 16,
    parameter int INST_W     = 16,
    parameter int MEM_DEPTH  = 256,
    parameter int FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            prog_we,
    input  logic [ADDR_W-1:0]               prog_addr,
    input  logic [INST_W-1:0]               prog_data,
    input  logic                            redirect_valid,
    input  logic [ADDR_W-1:0]               redirect_pc,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [INST_W-1:0]               out_inst,
    output logic [ADDR_W-1:0]               out_pc,
    output logic [ADDR_W-1:0]               fetch_pc,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
    localparam int MW = $clog2(MEM_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [INST_W-1:0] mem [MEM_DEPTH];
    logic [INST_W-1:0] fifo_inst_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q [FIFO_DEPTH];

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rd_pc_q, rd_pc_d;
    logic              rd_valid_q, rd_valid_d;
    logic [INST_W-1:0] rd_data_q;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW:0]       occupancy;
    logic              issue, push, pop;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{prog_addr, fetch_pc_q};

    // Handshake: the head transfers on any rising edge where out_valid && out_ready;
    // out_pc/out_inst hold steady while out_valid=1 and out_ready=0.
    assign out_valid  = (count_q != '0);
    assign out_inst   = out_valid ? fifo_inst_q[rd_ptr_q] : '0;
    assign out_pc     = out_valid ? fifo_pc_q[rd_ptr_q] : '0;
    assign fetch_pc   = fetch_pc_q;
    assign fifo_count = count_q;

    always_comb begin
        // Counting the in-flight read reserves its FIFO slot, so push never stalls.
        occupancy  = {1'b0, count_q} + (CW+1)'(rd_valid_q);
        issue      = !redirect_valid && (occupancy < (CW+1)'(FIFO_DEPTH));
        push       = rd_valid_q && !redirect_valid;
        pop        = out_valid && out_ready;
        fetch_pc_d = fetch_pc_q;
        rd_pc_d    = rd_pc_q;
        rd_valid_d = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            rd_valid_d = issue;
            if (issue) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                rd_pc_d    = fetch_pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (!push && pop) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rd_pc_q    <= '0;
            rd_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_pc_q    <= rd_pc_d;
            rd_valid_q <= rd_valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Memory is deliberately unreset so a program survives rst_n; reads are read-first.
    always_ff @(posedge clk) begin
        if (prog_we) mem[prog_addr[MW-1:0]] <= prog_data;
        if (issue)   rd_data_q <= mem[fetch_pc_q[MW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst_q[wr_ptr_q] <= rd_data_q;
            fifo_pc_q[wr_ptr_q]   <= rd_pc_q;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects, PC wrap,
// address aliasing and mid-stream reset, each checked against hand-derived values.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prog_we = 1'b0;
  logic [15:0] prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_inst;
  logic [15:0] out_pc;
  logic [15:0] fetch_pc;
  logic [2:0]  fifo_count;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_mem [256];

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .fetch_pc(fetch_pc), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // All driving and sampling happens 1ns after a rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic prog_write(input logic [15:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    step(1);
    prog_we = 1'b0;
    exp_mem[a[7:0]] = d;
  endtask

  task automatic redirect(input logic [15:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    step(1);
    redirect_valid = 1'b0;
  endtask

  // Accepts n heads with out_ready=1, expecting consecutive pcs from start_pc.
  task automatic collect(input int n, input logic [15:0] start_pc, input string name);
    int got = 0;
    logic [15:0] p;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < n; cyc++) begin
      if (out_valid) begin
        p = start_pc + 16'(got);
        checks++;
        if (out_pc !== p || out_inst !== exp_mem[p[7:0]]) begin
          errors++;
          $display("FAIL %s[%0d]: got pc=%h inst=%h, expected pc=%h inst=%h",
                   name, got, out_pc, out_inst, p, exp_mem[p[7:0]]);
        end
        got++;
      end
      if (got < n) step(1);
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d entries, expected %0d", name, got, n);
    end
  endtask

  task automatic test_reset;
    logic [15:0] prog [4];
    prog[0] = 16'h3260; prog[1] = 16'h34A0; prog[2] = 16'h0261; prog[3] = 16'h04A3;
    rst_n = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 256; i++)
      prog_write(16'(i), (i < 4) ? prog[i] : (16'hA000 | 16'(i)));
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0 || fetch_pc !== 16'h0000 ||
        out_inst !== 16'h0000 || out_pc !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: valid=%b count=%0d fetch_pc=%h inst=%h pc=%h, expected 0 0 0000 0000 0000",
               out_valid, fifo_count, fetch_pc, out_inst, out_pc);
    end
    rst_n = 1'b1;
    step(1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_valid_edge1: out_valid=%b, expected 0", out_valid);
    end
    step(1);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_valid_edge2: out_valid=%b, expected 1", out_valid);
    end
    collect(4, 16'h0000, "stream");
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(6);
    checks++;
    if (fifo_count !== 3'd4 || fetch_pc !== 16'h0004 || out_pc !== 16'h0000 ||
        out_inst !== 16'h3260) begin
      errors++;
      $display("FAIL backpressure_sat: count=%0d fetch_pc=%h head=(%h,%h), expected 4 0004 (0000,3260)",
               fifo_count, fetch_pc, out_pc, out_inst);
    end
    collect(8, 16'h0000, "drain");
  endtask

  task automatic test_redirect_flush;
    out_ready = 1'b0;
    redirect(16'h0005);
    step(6);
    checks++;
    if (fifo_count !== 3'd4 || out_pc !== 16'h0005 || fetch_pc !== 16'h0009) begin
      errors++;
      $display("FAIL flush_setup: count=%0d head=%h fetch_pc=%h, expected 4 0005 0009",
               fifo_count, out_pc, fetch_pc);
    end
    redirect(16'h000C);
    checks++;
    if (fifo_count !== 3'd0 || out_valid !== 1'b0 || fetch_pc !== 16'h000C) begin
      errors++;
      $display("FAIL flush_clear: count=%0d valid=%b fetch_pc=%h, expected 0 0 000c",
               fifo_count, out_valid, fetch_pc);
    end
    collect(2, 16'h000C, "after_flush");
  endtask

  task automatic test_accept_with_redirect;
    out_ready = 1'b0;
    redirect(16'h0005);
    step(2);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 16'h0005) begin
      errors++;
      $display("FAIL accept_setup: valid=%b head=%h, expected 1 0005", out_valid, out_pc);
    end
    out_ready = 1'b1;
    redirect(16'h0014);
    checks++;
    if (fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL accept_flush: count=%0d, expected 0", fifo_count);
    end
    collect(2, 16'h0014, "accept_redir");
  endtask

  task automatic test_pc_wrap;
    out_ready = 1'b0;
    redirect(16'hFFFE);
    collect(3, 16'hFFFE, "wrap");
  endtask

  task automatic test_alias;
    out_ready = 1'b0;
    prog_write(16'h0310, 16'hBEEF);
    redirect(16'h0510);
    collect(1, 16'h0510, "alias");
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    redirect(16'h0000);
    step(4);
    checks++;
    if (fifo_count !== 3'd3) begin
      errors++;
      $display("FAIL midreset_setup: count=%0d, expected 3", fifo_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0 || fetch_pc !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_async: valid=%b count=%0d fetch_pc=%h, expected 0 0 0000",
               out_valid, fifo_count, fetch_pc);
    end
    step(1);
    rst_n = 1'b1;
    collect(4, 16'h0000, "restart");
  endtask

  initial begin
    test_reset;
    test_backpressure;
    test_redirect_flush;
    test_accept_with_redirect;
    test_pc_wrap;
    test_alias;
    test_reset_midstream;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
